// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes, FSM states, default width.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_e;
endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO unit: WIDTH-cycle shift-add multiply and restoring divide on magnitudes, plus MTHI/MTLO.
// Divide datapath only exists with MDU_DIV_EN defined; otherwise DIV/DIVU run full latency as no-ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH-1:0]   b_mag_q;
  logic               div_q;
  logic               neg_q;
  logic               wr_res;
  logic               accept;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;

  always_comb begin
    accept    = start && (state != RUN);
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = is_signed & rs_val[WIDTH-1];
    b_neg     = is_signed & rt_val[WIDTH-1];
    a_mag     = a_neg ? -rs_val : rs_val;
    b_mag     = b_neg ? -rt_val : rt_val;
    // Multiply step: conditionally add multiplicand into the upper half, then shift right with carry.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_mag_q : {WIDTH{1'b0}})};
  end

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] a_orig_q;
  logic             neg_r_q;
  logic             dz_q;
  logic [WIDTH:0]   top;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  always_comb begin
    // Divide step: shift the remainder:dividend pair left, trial-subtract, quotient bit enters at LSB.
    top  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge   = (top >= {1'b0, b_mag_q});
    diff = top[WIDTH-1:0] - b_mag_q;
    if (div_q) begin
      step = {(ge ? diff : top[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end else begin
      step = {mul_sum, acc[WIDTH-1:1]};
    end
    quo    = neg_q   ? -step[WIDTH-1:0]       : step[WIDTH-1:0];
    rem    = neg_r_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    wr_res = 1'b1;
    if (!div_q) begin
      res = neg_q ? -step : step;
    end else if (dz_q) begin
      res = {a_orig_q, {WIDTH{1'b1}}};
    end else begin
      res = {rem, quo};
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_orig_q <= '0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      a_orig_q <= rs_val;
      neg_r_q  <= a_neg;
      dz_q     <= (rt_val == '0);
    end
  end
`else
  always_comb begin
    step   = {mul_sum, acc[WIDTH-1:1]};
    res    = neg_q ? -step : step;
    wr_res = !div_q;
  end
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      b_mag_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (accept) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= CW'(WIDTH - 1);
            acc     <= {{WIDTH{1'b0}}, a_mag};
            b_mag_q <= b_mag;
            div_q   <= op[1];
            neg_q   <= a_neg ^ b_neg;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= step;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (wr_res) begin
              hi <= res[2*WIDTH-1:WIDTH];
              lo <= res[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
